// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit holding the HI/LO registers: one shift-add or
// restoring-divide step per cycle on operand magnitudes, signs applied in a final FIX cycle.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               rem_neg_q, rem_neg_d;
  logic               done_q, done_d;

  logic               is_signed;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     add_sum, rem_sh, rem_sub;
  logic               rem_ge;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    done_d    = 1'b0;

    is_signed = ~op[0];
    a_mag     = (is_signed && a[WIDTH-1]) ? -a : a;
    b_mag     = (is_signed && b[WIDTH-1]) ? -b : b;

    // Multiply: acc = {partial product, remaining multiplier bits}.
    // Divide:   acc = {partial remainder, remaining dividend / quotient bits}.
    add_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
    rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    rem_ge   = (rem_sh >= {1'b0, opnd_q});
    rem_sub  = rem_sh - {1'b0, opnd_q};

    prod_fix = neg_q ? -acc_q : acc_q;
    quo_fix  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    case (state_q)
      IDLE: begin
        if (start) begin
          case (op)
            3'b100: hi_d = a;
            3'b101: lo_d = a;
            3'b000, 3'b001, 3'b010, 3'b011: begin
              state_d   = CALC;
              cnt_d     = '0;
              is_div_d  = op[1];
              neg_d     = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
              rem_neg_d = is_signed & a[WIDTH-1];
              opnd_d    = op[1] ? b_mag : a_mag;
              acc_d     = {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
            end
            default: ;
          endcase
        end
      end
      CALC: begin
        if (is_div_q) begin
          if (rem_ge) acc_d = {rem_sub[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          else        acc_d = {rem_sh[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b0};
        end else begin
          acc_d = acc_q[0] ? {add_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (is_div_q) begin
          // A zero divisor naturally leaves remainder = dividend; only the quotient is forced.
          lo_d = (opnd_q == '0) ? '1 : quo_fix;
          hi_d = rem_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      done_q    <= done_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q != IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: vector table through a done-driven scoreboard, plus
// hazard, reset-abort and WIDTH=8 sequences.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset, start, busy, done;
  logic [2:0]  op;
  logic [31:0] a, b, hi, lo;
  logic        start8, busy8, done8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8, hi8, lo8;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  mult_div_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
    .hi(hi8), .lo(lo8), .busy(busy8), .done(done8)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
    string       name;
  } vec_t;

  typedef struct {
    logic [31:0] hi, lo;
    string       name;
  } exp_t;

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1 expected no pending result");
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.name, "_hilo"}, {hi, lo}, {mon_e.hi, mon_e.lo});
      end
    end
  end

  // Called at a negedge; returns at the negedge where done is seen.
  task automatic run_op(input logic [2:0] o, input logic [31:0] av, bv, eh, el, input string name);
    logic [31:0] h0, l0;
    int k, busy_cnt;
    bit hold_ok;
    h0 = hi; l0 = lo;
    op = o; a = av; b = bv; start = 1'b1;
    sb.push_back('{eh, el, name});
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom;
    busy_cnt = 0; hold_ok = 1'b1;
    for (k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (done) break;
      if (busy) busy_cnt++;
      if (hi !== h0 || lo !== l0) hold_ok = 1'b0;
    end
    check({name, "_latency"}, 64'(k), 64'd34);
    check({name, "_busy_cycles"}, 64'(busy_cnt), 64'd33);
    check({name, "_hold"}, 64'(hold_ok), 64'd1);
    $display("[TB] %s op=%b a=%h b=%h -> hi=%h lo=%h", name, o, av, bv, hi, lo);
  endtask

  task automatic mt(input logic [2:0] o, input logic [31:0] av, input string name);
    op = o; a = av; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check({name, "_reg"}, (o == 3'b100) ? 64'(hi) : 64'(lo), 64'(av));
    check({name, "_busy_done"}, {62'd0, busy, done}, 64'd0);
    $display("[TB] %s op=%b a=%h -> hi=%h lo=%h", name, o, av, hi, lo);
  endtask

  task automatic run8(input logic [2:0] o, input logic [7:0] av, bv, eh, el, input string name);
    int k, busy_cnt;
    op8 = o; a8 = av; b8 = bv; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    busy_cnt = 0;
    for (k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (done8) break;
      if (busy8) busy_cnt++;
    end
    check({name, "_latency"}, 64'(k), 64'd10);
    check({name, "_busy_cycles"}, 64'(busy_cnt), 64'd9);
    check({name, "_hilo"}, {48'd0, hi8, lo8}, {48'd0, eh, el});
    $display("[TB] %s op=%b a=%h b=%h -> hi=%h lo=%h", name, o, av, bv, hi8, lo8);
  endtask

  initial begin
    int busy_seen, done_cnt;
    logic [31:0] h0;
    bit hold_ok;

    vecs[0]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max"};
    vecs[1]  = '{3'b000, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, "mult_neg3x5"};
    vecs[2]  = '{3'b010, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg7by2"};
    vecs[3]  = '{3'b011, 32'd100,      32'd7,        32'd2,        32'd14,       "divu_100by7"};
    vecs[4]  = '{3'b011, 32'h1234,     32'd0,        32'h1234,     32'hFFFFFFFF, "divu_by0"};
    vecs[5]  = '{3'b010, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, "div_min_by_m1"};
    vecs[6]  = '{3'b010, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, "div_7by_neg2"};
    vecs[7]  = '{3'b010, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd3,        "div_neg7by_neg2"};
    vecs[8]  = '{3'b010, 32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, 32'hFFFFFFFF, "div_neg8_by0"};
    vecs[9]  = '{3'b000, 32'h80000000, 32'h80000000, 32'h40000000, 32'd0,        "mult_min_sq"};
    vecs[10] = '{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd1,        "mult_m1_sq"};
    vecs[11] = '{3'b001, 32'h00010000, 32'h00010000, 32'd1,        32'd0,        "multu_2p32"};
    vecs[12] = '{3'b000, 32'h7FFFFFFF, 32'd2,        32'd0,        32'hFFFFFFFE, "mult_max_x2"};
    vecs[13] = '{3'b011, 32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, "divu_by1"};

    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
    repeat (2) @(negedge clk);
    check("reset_state", {hi, lo}, 64'd0);
    check("reset_busy_done", {60'd0, busy, done, busy8, done8}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Back-to-back: each op is launched in the cycle its predecessor pulses done.
    foreach (vecs[i]) run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].name);
    @(negedge clk);
    check("done_single_pulse", 64'(done), 64'd0);

    // Requests while busy must be ignored and operands held from accept.
    op = 3'b001; a = 32'd6; b = 32'd7; start = 1'b1;
    sb.push_back('{32'd0, 32'd42, "hazard_mul"});
    h0 = hi;
    @(posedge clk); #1;
    op = 3'b011; a = 32'd9; b = 32'd3;
    repeat (5) begin @(posedge clk); #1; a = $urandom; b = $urandom; end
    op = 3'b100; a = 32'hCAFE;
    repeat (3) @(posedge clk);
    #1 start = 1'b0;
    hold_ok = 1'b1;
    done_cnt = 0;
    for (int k = 0; k < 60 && done_cnt == 0; k++) begin
      @(negedge clk);
      if (done) done_cnt++;
      else if (hi !== h0) hold_ok = 1'b0;
    end
    check("hazard_done_seen", 64'(done_cnt), 64'd1);
    check("hazard_mthi_ignored", 64'(hold_ok), 64'd1);
    $display("[TB] hazard_mul 6*7 with ignored DIVU/MTHI -> hi=%h lo=%h", hi, lo);
    mt(3'b100, 32'hCAFE, "mthi_after_done");
    busy_seen = 0;
    repeat (40) begin @(negedge clk); if (busy) busy_seen++; end
    check("hazard_no_late_start", 64'(busy_seen), 64'd0);

    // Reset mid-operation aborts it with no result.
    mt(3'b100, 32'hAA, "mthi_aa");
    mt(3'b101, 32'hBB, "mtlo_bb");
    op = 3'b001; a = 32'd5; b = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_hilo", {hi, lo}, 64'd0);
    check("abort_busy_done", {62'd0, busy, done}, 64'd0);
    busy_seen = 0;
    repeat (40) begin @(negedge clk); if (busy || done) busy_seen++; end
    check("abort_quiet", 64'(busy_seen), 64'd0);
    check("abort_hilo_after", {hi, lo}, 64'd0);
    $display("[TB] reset_abort multu 5*5 -> hi=%h lo=%h", hi, lo);

    run8(3'b001, 8'hFF, 8'hFF, 8'hFE, 8'h01, "w8_multu_max");
    run8(3'b010, 8'h80, 8'hFF, 8'h00, 8'h80, "w8_div_min_by_m1");

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Iterative, parametrised multiply/divide unit holding the architectural HI/LO registers for the MIPS-compatible core. It sits beside the combinational ALU in the execute stage. It covers MULT, MULTU, DIV, DIVU, MTHI and MTLO, which the single-cycle ALU does not implement. The unit runs one shift-add or restoring-divide step per cycle, and the pipeline stalls on busy.

Parameters:
WIDTH, 32, operand width and width of each of HI and LO; must be at least 4.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  single-cycle request; sampled only when busy=0
op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 no-op
a  input  WIDTH  rs operand; dividend / multiplicand / MTHI-MTLO data
b  input  WIDTH  rt operand; divisor / multiplier
hi  output  WIDTH  HI register (MFHI source)
lo  output  WIDTH  LO register (MFLO source)
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when hi/lo receive a MULT/DIV result

Behaviour:
- Reset (synchronous, at the clock edge with reset=1): state IDLE, hi=0, lo=0, busy=0, done=0, internal counter=0. Reset overrides start. Reset mid-operation aborts it and leaves no partial hi/lo update.
- States: IDLE, CALC, FIX.
- IDLE:
  - start=1 with op MTHI: hi<=a at the edge. busy stays 0, done stays 0.
  - start=1 with op MTLO: lo<=a at the edge. busy stays 0, done stays 0.
  - start=1 with op 000-011: latch a, b and op, go to CALC, busy=1.
  - start=1 with op 110/111: ignored.
- CALC:
  - Exactly WIDTH cycles, counter 0..WIDTH-1, then FIX.
  - Multiply: shift-add on operand magnitudes into a 2*WIDTH accumulator.
  - Divide: restoring division on magnitudes, one quotient bit per cycle.
- FIX (1 cycle):
  - Apply signs for signed ops.
  - Product sign = sign(a) XOR sign(b).
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder takes the sign of the dividend.
  - At the edge leaving FIX: hi/lo are written, state returns to IDLE, busy=0, done=1 for exactly one cycle.
- Latency: a start accepted at edge N gives new hi/lo, done=1 and busy=0 after edge N+WIDTH+1. busy is high for WIDTH+1 cycles.
- Results:
  - Multiply: {hi,lo} = full 2*WIDTH-bit product.
  - Divide: lo = quotient, hi = remainder.
- Magnitudes are WIDTH-bit unsigned, so |MIN_INT| = 2^(WIDTH-1) is exact.
- Signed DIV of MIN_INT by -1: lo = MIN_INT (wraps), hi = 0.
- Divide by zero (signed or unsigned): lo = all ones, hi = a unchanged. Full latency still applies; no exception is raised.
- start while busy=1: ignored for all ops, including MTHI/MTLO. Operands latched at accept are held; later changes on a/b have no effect.
- hi/lo hold their previous values throughout CALC and FIX and change only at the FIX exit edge or on MTHI/MTLO.
- A new start may be accepted in the same cycle that done=1, since busy=0 in that cycle.

Test Plan:
1. WIDTH=32, MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> after 33 cycles hi=0xFFFFFFFE, lo=0x00000001, done pulses once, busy high for exactly 33 cycles.
2. MULT a=-3 (0xFFFFFFFD), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Then DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIVU a=100, b=7 -> lo=14, hi=2.
3. Divide corner cases:
   - DIVU a=0x1234, b=0 -> lo=0xFFFFFFFF, hi=0x1234.
   - DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
4. Hazards during busy:
   - Start MULTU 6*7.
   - Assert start with DIVU 9/3 while busy; change a/b mid-operation -> result hi=0, lo=42, second request ignored.
   - MTHI a=0xCAFE issued while busy -> ignored.
   - MTHI a=0xCAFE issued after done -> hi=0xCAFE next cycle, busy stays 0.
5. Assert reset at cycle 10 of a MULTU 5*5 with hi/lo previously set via MTHI/MTLO to 0xAA/0xBB -> next cycle hi=0, lo=0, busy=0, done=0, and no done pulse follows.
6. WIDTH=8, MULTU 0xFF*0xFF -> hi=0xFE, lo=0x01 after 9 cycles. Then DIV a=0x80, b=0xFF -> lo=0x80, hi=0x00.
